// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, combinational ROM read and a decoupling fetch queue.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IADDR_W  = 6,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        stall,
  input  logic [1:0]                  pcsource,
  input  logic [XLEN-1:0]             bpc,
  input  logic [XLEN-1:0]             jpc,
  output logic [IADDR_W-1:0]          imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        id_ready,
  output logic                        if_valid,
  output logic [XLEN-1:0]             if_pc,
  output logic [XLEN-1:0]             if_pc4,
  output logic [XLEN-1:0]             if_inst,
  output logic [$clog2(FQ_DEPTH):0]   fq_count,
  output logic                        fq_full,
  output logic [XLEN-1:0]             PC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_fetch,
  output logic [31:0]                 perf_flush,
  output logic [31:0]                 perf_full
`endif
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [XLEN-1:0]  r_mem_pc   [FQ_DEPTH];
  logic [XLEN-1:0]  r_mem_pc4  [FQ_DEPTH];
  logic [XLEN-1:0]  r_mem_inst [FQ_DEPTH];

  logic             w_redirect;
  logic [XLEN-1:0]  w_target_raw;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_pc4;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_redirect = (pcsource != 2'b00);

  always_comb begin
    w_target_raw = '0;
    unique case (pcsource)
      2'b01:   w_target_raw = bpc;
      2'b10:   w_target_raw = jpc;
      default: w_target_raw = '0;
    endcase
  end

  // Targets are always word aligned.
  assign w_target = w_target_raw & ~(XLEN'(3));
  assign w_pc4    = r_pc + XLEN'(4);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FQ_DEPTH));
  assign w_pop   = !w_empty && id_ready && !stall && !w_redirect;
  // A pop frees the slot the same cycle, so a full queue can still accept.
  assign w_push  = !w_redirect && !stall && (!w_full || w_pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redirect) begin
      r_pc     <= w_target;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= w_pc4;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_pc4[r_wr_ptr]  <= w_pc4;
      r_mem_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_addr = r_pc[IADDR_W+1:2];
  assign PC        = r_pc;
  assign fq_count  = r_count;
  assign fq_full   = w_full;
  assign if_valid  = !w_empty;
  assign if_pc     = w_empty ? '0 : r_mem_pc[r_rd_ptr];
  assign if_pc4    = w_empty ? '0 : r_mem_pc4[r_rd_ptr];
  assign if_inst   = w_empty ? '0 : r_mem_inst[r_rd_ptr];

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_full;

  // perf_flush keeps counting through stall because redirects override it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_full  <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_redirect) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
      if (w_full && !w_pop && !stall) begin
        r_perf_full <= r_perf_full + 32'd1;
      end
    end
  end

  assign perf_fetch = r_perf_fetch;
  assign perf_flush = r_perf_flush;
  assign perf_full  = r_perf_full;
`else
  // Counters absent: no extra state or ports in this build.
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a queue-based reference model feeds a scoreboard
// that a negedge monitor compares and pops on every ID handshake.
module tb_if_fetch_queue;

  localparam int          XLEN    = 32;
  localparam int          IADDR_W = 6;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] RST_PC  = 32'h0;
  localparam int          NCYC    = 1600;

  logic              clk = 1'b0;
  logic              clrn;
  logic              stall;
  logic [1:0]        pcsource;
  logic [31:0]       bpc;
  logic [31:0]       jpc;
  logic [IADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              id_ready;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_pc4;
  logic [31:0]       if_inst;
  logic [2:0]        fq_count;
  logic              fq_full;
  logic [31:0]       PC;
`ifdef IF_PERF_CNT_EN
  logic [31:0]       perf_fetch;
  logic [31:0]       perf_flush;
  logic [31:0]       perf_full;
`endif

  logic [31:0] rom [64];
  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN(XLEN), .IADDR_W(IADDR_W), .FQ_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .clrn(clrn), .stall(stall), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
    .if_inst(if_inst), .fq_count(fq_count), .fq_full(fq_full), .PC(PC)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_flush(perf_flush), .perf_full(perf_full)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch, m_flush, m_full;
  bit          mon_popped;
  bit          done;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare visible state against the model, pop on each accepted head.
  always @(negedge clk) begin
    if (!done) begin
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      chk("fq_count", 32'(fq_count), 32'(exp_q.size()));
      chk("fq_full", 32'(fq_full), 32'(exp_q.size() == DEPTH));
      chk("PC", PC, m_pc);
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[7:2]));
      if (if_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL head: actual valid pc %h required empty queue at %0t", if_pc, $time);
        end else begin
          chk("head_pc", if_pc, exp_q[0].pc);
          chk("head_pc4", if_pc4, exp_q[0].pc4);
          chk("head_inst", if_inst, exp_q[0].inst);
          if (clrn && id_ready && !stall && pcsource == 2'b00) begin
            void'(exp_q.pop_front());
            mon_popped = 1'b1;
          end
        end
      end else begin
        chk("empty_pc", if_pc, 32'h0);
        chk("empty_pc4", if_pc4, 32'h0);
        chk("empty_inst", if_inst, 32'h0);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch, m_fetch);
      chk("perf_flush", perf_flush, m_flush);
      chk("perf_full", perf_full, m_full);
`endif
    end
  end

  // Advance the reference model by one clock using the inputs that were applied.
  task automatic model_step();
    bit          popped;
    int          sz;
    logic [31:0] tgt;
    popped     = mon_popped;
    mon_popped = 1'b0;
    sz         = exp_q.size() + (popped ? 1 : 0);
    if (pcsource != 2'b00) begin
      tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? jpc : 32'h0;
      if (!stall && sz == DEPTH) m_full++;
      exp_q.delete();
      m_pc = tgt & 32'hFFFF_FFFC;
      m_flush++;
    end else if (!stall) begin
      if (sz < DEPTH || popped) begin
        exp_q.push_back('{pc: m_pc, pc4: m_pc + 32'd4, inst: rom[m_pc[7:2]]});
        m_pc = m_pc + 32'd4;
        m_fetch++;
      end else begin
        m_full++;
      end
    end
  endtask

  task automatic pick_inputs(input int cyc);
    int ph;
    bit redir;
    ph = (cyc / 200) % 4;
    case (ph)
      0: begin
        id_ready = ($urandom % 10) < 9;
        stall    = ($urandom % 20) == 0;
        redir    = ($urandom % 30) == 0;
      end
      1: begin
        id_ready = ($urandom % 5) == 0;
        stall    = ($urandom % 20) == 0;
        redir    = ($urandom % 50) == 0;
      end
      2: begin
        id_ready = ($urandom % 2) == 0;
        stall    = ($urandom % 5) < 2;
        redir    = ($urandom % 10) == 0;
      end
      default: begin
        id_ready = 1'b1;
        stall    = 1'b0;
        redir    = ($urandom % 40) == 0;
      end
    endcase
    pcsource = redir ? 2'($urandom_range(1, 3)) : 2'b00;
    bpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
    jpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
  endtask

  initial begin
    bit skip;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    clrn       = 1'b0;
    stall      = 1'b0;
    pcsource   = 2'b00;
    bpc        = '0;
    jpc        = '0;
    id_ready   = 1'b0;
    m_pc       = RST_PC;
    m_fetch    = '0;
    m_flush    = '0;
    m_full     = '0;
    mon_popped = 1'b0;
    done       = 1'b0;
    skip       = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (skip) begin
        skip = 1'b0;
        clrn = 1'b1;
      end else begin
        model_step();
      end
      if (cyc == 350 || cyc == 1100) begin
        clrn = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_PC", PC, RST_PC);
        chk("rst_fq_count", 32'(fq_count), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch, 32'h0);
        chk("rst_perf_flush", perf_flush, 32'h0);
        chk("rst_perf_full", perf_full, 32'h0);
`endif
        exp_q.delete();
        m_pc       = RST_PC;
        m_fetch    = '0;
        m_flush    = '0;
        m_full     = '0;
        mon_popped = 1'b0;
        skip       = 1'b1;
      end
      pick_inputs(cyc);
    end
    @(negedge clk);
    #1 done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
